// File: rtl/sockit_i2c_slave.sv
// sockit_i2c_slave
//   I2C target with a fixed 7-bit address. Converts bus writes into a byte
//   strobe for local logic and serves bus reads from a valid/ready source,
//   stretching SCL while no read byte is available.
//
// Parameters
//   ADR  own 7-bit device address
//   FLT  glitch-filter length; a filtered line follows its input only after
//        FLT consecutive equal samples
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   scl_i, sda_i    raw (asynchronous) bus line samples
//   scl_e, sda_e    open-drain pull-low enables (1 = drive line low)
//   rx_vld, rx_dat  one-clk strobe with the written byte; byte held until next strobe
//   rx_rdy          local side accepts the byte (sampled at bit 8, 0 = NACK)
//   tx_vld, tx_dat  read byte offered by the local side
//   tx_rdy          target is waiting for a read byte (transfer on tx_vld & tx_rdy)
//   busy            addressed and inside a transaction
//   sto             one-clk pulse on every STOP condition
module sockit_i2c_slave #(
    parameter logic [6:0]  ADR = 7'h26,
    parameter int unsigned FLT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    output logic       scl_e,
    input  logic       sda_i,
    output logic       sda_e,
    output logic       rx_vld,
    output logic [7:0] rx_dat,
    input  logic       rx_rdy,
    input  logic       tx_vld,
    input  logic [7:0] tx_dat,
    output logic       tx_rdy,
    output logic       busy,
    output logic       sto
);

    localparam int unsigned CW = (FLT > 1) ? $clog2(FLT) : 1;
    localparam logic [CW-1:0] FLT_M1 = CW'(FLT - 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, A_ACK, WR, W_ACK, RD_LD, RD, R_ACK, IGNORE
    } state_t;

    // ------------------------------------------------------------------
    // Input path: 2-FF synchronizer, then the FLT-sample filter
    // ------------------------------------------------------------------
    logic [1:0]    scl_sy, sda_sy;
    logic [CW-1:0] scl_c, sda_c;
    logic          scl_f, sda_f;
    logic          scl_d, sda_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sy <= '1;
            sda_sy <= '1;
            scl_c  <= '0;
            sda_c  <= '0;
            scl_f  <= 1'b1;
            sda_f  <= 1'b1;
            scl_d  <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_sy <= {scl_sy[0], scl_i};
            sda_sy <= {sda_sy[0], sda_i};

            if (scl_sy[1] == scl_f) begin
                scl_c <= '0;
            end else if (scl_c == FLT_M1) begin
                scl_f <= scl_sy[1];
                scl_c <= '0;
            end else begin
                scl_c <= scl_c + 1'b1;
            end

            if (sda_sy[1] == sda_f) begin
                sda_c <= '0;
            end else if (sda_c == FLT_M1) begin
                sda_f <= sda_sy[1];
                sda_c <= '0;
            end else begin
                sda_c <= sda_c + 1'b1;
            end

            scl_d <= scl_f;
            sda_d <= sda_f;
        end
    end

    logic scl_rise, scl_fall, start_c, stop_c;

    assign scl_rise = scl_f & ~scl_d;
    assign scl_fall = ~scl_f & scl_d;
    // SCL must be high on both samples so that an SDA change coinciding with
    // an SCL edge is never mistaken for START/STOP.
    assign start_c  = scl_f & scl_d & sda_d & ~sda_f;
    assign stop_c   = scl_f & scl_d & ~sda_d & sda_f;

    // ------------------------------------------------------------------
    // Protocol FSM
    // ------------------------------------------------------------------
    state_t     state, state_n;
    logic [2:0] cnt, cnt_n;
    logic [7:0] sr, sr_n;
    logic       ph, ph_n;       // second half of an ACK bit / master ACK seen
    logic       ackf, ackf_n;   // ACK decision for the written byte
    logic       rw, rw_n;
    logic       sda_n, scl_n, rxv_n, txr_n, busy_n, sto_n;
    logic [7:0] rxd_n;
    logic [7:0] byte_in;

    assign byte_in = {sr[6:0], sda_f};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            sr     <= '0;
            ph     <= 1'b0;
            ackf   <= 1'b0;
            rw     <= 1'b0;
            sda_e  <= 1'b0;
            scl_e  <= 1'b0;
            rx_vld <= 1'b0;
            rx_dat <= '0;
            tx_rdy <= 1'b0;
            busy   <= 1'b0;
            sto    <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            sr     <= sr_n;
            ph     <= ph_n;
            ackf   <= ackf_n;
            rw     <= rw_n;
            sda_e  <= sda_n;
            scl_e  <= scl_n;
            rx_vld <= rxv_n;
            rx_dat <= rxd_n;
            tx_rdy <= txr_n;
            busy   <= busy_n;
            sto    <= sto_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sr_n    = sr;
        ph_n    = ph;
        ackf_n  = ackf;
        rw_n    = rw;
        sda_n   = sda_e;
        scl_n   = scl_e;
        rxv_n   = 1'b0;
        rxd_n   = rx_dat;
        txr_n   = tx_rdy;
        busy_n  = busy;
        sto_n   = 1'b0;

        // rx_vld is a registered pulse, so a strobe already issued still
        // completes when START/STOP takes over here.
        if (start_c) begin
            state_n = ADDR;
            cnt_n   = '0;
            ph_n    = 1'b0;
            sda_n   = 1'b0;
            scl_n   = 1'b0;
            txr_n   = 1'b0;
            busy_n  = 1'b0;
        end else if (stop_c) begin
            state_n = IDLE;
            cnt_n   = '0;
            ph_n    = 1'b0;
            sda_n   = 1'b0;
            scl_n   = 1'b0;
            txr_n   = 1'b0;
            busy_n  = 1'b0;
            sto_n   = 1'b1;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise) begin
                        sr_n  = byte_in;
                        cnt_n = cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            cnt_n   = '0;
                            ph_n    = 1'b0;
                            rw_n    = sda_f;
                            state_n = (byte_in[7:1] == ADR) ? A_ACK : IGNORE;
                        end
                    end
                end

                A_ACK: begin
                    if (scl_fall) begin
                        if (!ph) begin
                            ph_n   = 1'b1;
                            sda_n  = 1'b1;
                            busy_n = 1'b1;
                        end else begin
                            ph_n  = 1'b0;
                            sda_n = 1'b0;
                            cnt_n = '0;
                            if (rw) begin
                                state_n = RD_LD;
                                scl_n   = 1'b1;
                                txr_n   = 1'b1;
                            end else begin
                                state_n = WR;
                            end
                        end
                    end
                end

                WR: begin
                    if (scl_rise) begin
                        sr_n  = byte_in;
                        cnt_n = cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            cnt_n   = '0;
                            ph_n    = 1'b0;
                            ackf_n  = rx_rdy;
                            state_n = W_ACK;
                            if (rx_rdy) begin
                                rxd_n = byte_in;
                                rxv_n = 1'b1;
                            end
                        end
                    end
                end

                W_ACK: begin
                    if (scl_fall) begin
                        if (!ph) begin
                            ph_n  = 1'b1;
                            sda_n = ackf;
                        end else begin
                            ph_n    = 1'b0;
                            sda_n   = 1'b0;
                            state_n = WR;
                        end
                    end
                end

                RD_LD: begin
                    // Bit 7 goes straight onto SDA; the shift register keeps
                    // the remaining bits left-aligned so sr[7] is always next.
                    if (tx_vld && tx_rdy) begin
                        sr_n    = {tx_dat[6:0], 1'b0};
                        sda_n   = ~tx_dat[7];
                        scl_n   = 1'b0;
                        txr_n   = 1'b0;
                        cnt_n   = '0;
                        state_n = RD;
                    end
                end

                RD: begin
                    if (scl_fall) begin
                        if (cnt == 3'd7) begin
                            sda_n   = 1'b0;
                            cnt_n   = '0;
                            ph_n    = 1'b0;
                            state_n = R_ACK;
                        end else begin
                            sda_n = ~sr[7];
                            sr_n  = {sr[6:0], 1'b0};
                            cnt_n = cnt + 3'd1;
                        end
                    end
                end

                R_ACK: begin
                    if (scl_rise) begin
                        if (!sda_f) begin
                            ph_n = 1'b1;
                        end else begin
                            state_n = IGNORE;
                        end
                    end else if (scl_fall && ph) begin
                        ph_n    = 1'b0;
                        state_n = RD_LD;
                        scl_n   = 1'b1;
                        txr_n   = 1'b1;
                    end
                end

                IDLE, IGNORE: begin
                end

                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sockit_i2c_slave.sv
// tb_sockit_i2c_slave
//   Directed bench: a bit-banged I2C master drives the wired-AND bus, a read
//   responder serves tx bytes, and monitors count strobes and stretch lengths.
module tb_sockit_i2c_slave;

    localparam int HP = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m, sda_m;
    logic       scl_i, sda_i;
    logic       scl_e, sda_e;
    logic       rx_vld;
    logic [7:0] rx_dat;
    logic       rx_rdy;
    logic       tx_vld = 1'b0;
    logic [7:0] tx_dat = '0;
    logic       tx_rdy;
    logic       busy, sto;

    always #5 clk = ~clk;

    assign scl_i = scl_m & ~scl_e;
    assign sda_i = sda_m & ~sda_e;

    sockit_i2c_slave #(.ADR(7'h26), .FLT(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .scl_i  (scl_i),
        .scl_e  (scl_e),
        .sda_i  (sda_i),
        .sda_e  (sda_e),
        .rx_vld (rx_vld),
        .rx_dat (rx_dat),
        .rx_rdy (rx_rdy),
        .tx_vld (tx_vld),
        .tx_dat (tx_dat),
        .tx_rdy (tx_rdy),
        .busy   (busy),
        .sto    (sto)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- monitors ----------------
    int rx_cnt = 0, rx_wide = 0, sto_cnt = 0, drive_cnt = 0, txr_rises = 0;
    int txr_cur = 0, txr_run = 0, scl_cur = 0, scl_run = 0;
    logic rx_prev = 1'b0, txr_prev = 1'b0, scl_prev = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (rx_vld) begin
                rx_cnt++;
                if (rx_prev) rx_wide++;
            end
            rx_prev = rx_vld;
            if (sto) sto_cnt++;
            if (sda_e || scl_e) drive_cnt++;
            if (tx_rdy && !txr_prev) txr_rises++;
            if (tx_rdy) txr_cur++;
            else begin
                if (txr_prev) txr_run = txr_cur;
                txr_cur = 0;
            end
            txr_prev = tx_rdy;
            if (scl_e) scl_cur++;
            else begin
                if (scl_prev) scl_run = scl_cur;
                scl_cur = 0;
            end
            scl_prev = scl_e;
        end
    end

    // ---------------- read responder ----------------
    logic [7:0] txq [64];
    int   tx_len = 0, tx_delay = 0;
    logic tx_pre = 1'b0;
    int   tx_idx = 0, hs_cnt = 0, tx_wait = 0;
    logic rdy_q = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (tx_vld && rdy_q) begin
                tx_vld = 1'b0;
                tx_idx++;
                hs_cnt++;
            end else if (!tx_vld && tx_idx < tx_len) begin
                if (tx_pre) begin
                    tx_vld = 1'b1;
                    tx_dat = txq[tx_idx];
                end else if (tx_rdy) begin
                    if (tx_wait >= tx_delay) begin
                        tx_vld  = 1'b1;
                        tx_dat  = txq[tx_idx];
                        tx_wait = 0;
                    end else begin
                        tx_wait++;
                    end
                end
            end
            rdy_q = tx_rdy;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    // ---------------- bus master ----------------
    task automatic hp();
        repeat (HP) @(negedge clk);
    endtask

    task automatic scl_up();
        int n;
        n = 0;
        scl_m = 1'b1;
        @(negedge clk);
        while (!scl_i && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!scl_i) check("scl_release", 32'(scl_i), 1);
    endtask

    task automatic start_c();
        sda_m = 1'b1;
        hp();
        scl_up();
        hp();
        sda_m = 1'b0;
        hp();
        scl_m = 1'b0;
        hp();
    endtask

    task automatic stop_c();
        sda_m = 1'b0;
        hp();
        scl_up();
        hp();
        sda_m = 1'b1;
        hp();
    endtask

    task automatic wbit(input logic b, input logic gl);
        sda_m = b;
        hp();
        scl_up();
        repeat (HP/2) @(negedge clk);
        if (gl) begin
            sda_m = ~b;
            @(negedge clk);
            sda_m = b;
        end
        repeat (HP/2) @(negedge clk);
        scl_m = 1'b0;
        hp();
    endtask

    task automatic rbit(output logic b);
        sda_m = 1'b1;
        hp();
        scl_up();
        hp();
        b = sda_i;
        scl_m = 1'b0;
        hp();
    endtask

    task automatic wbyte(input logic [7:0] d, input logic [7:0] gl, output logic ack);
        for (int i = 7; i >= 0; i--) wbit(d[i], gl[i]);
        rbit(ack);
    endtask

    task automatic rbyte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            d[i] = b;
        end
        wbit(nack, 1'b0);
    endtask

    // ---------------- directed tests ----------------
    logic       ack;
    logic       b;
    logic [7:0] d;
    int rx0, s0, d0, h0, r0;

    initial begin
        rst    = 1'b1;
        scl_m  = 1'b1;
        sda_m  = 1'b1;
        rx_rdy = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outs", 32'({scl_e, sda_e, rx_vld, rx_dat, tx_rdy, busy, sto}), 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // T1: write A5 to own address
        rx0 = rx_cnt; s0 = sto_cnt;
        start_c();
        wbyte({7'h26, 1'b0}, 8'h00, ack);
        check("t1_addr_ack", 32'(ack), 0);
        check("t1_busy_set", 32'(busy), 1);
        wbyte(8'hA5, 8'h00, ack);
        check("t1_data_ack", 32'(ack), 0);
        check("t1_rx_cnt", 32'(rx_cnt - rx0), 1);
        check("t1_rx_dat", 32'(rx_dat), 32'hA5);
        stop_c();
        repeat (10) @(negedge clk);
        check("t1_sto", 32'(sto_cnt - s0), 1);
        check("t1_busy_clr", 32'(busy), 0);

        // T2: foreign address is ignored
        rx0 = rx_cnt; d0 = drive_cnt;
        start_c();
        wbyte({7'h27, 1'b0}, 8'h00, ack);
        check("t2_addr_nack", 32'(ack), 1);
        wbyte(8'h3C, 8'h00, ack);
        check("t2_data_nack", 32'(ack), 1);
        stop_c();
        repeat (10) @(negedge clk);
        check("t2_rx_cnt", 32'(rx_cnt - rx0), 0);
        check("t2_no_drive", 32'(drive_cnt - d0), 0);

        // T3: read with 200-clk late data, master NACK
        txq[tx_idx] = 8'h96; tx_pre = 1'b0; tx_delay = 200; tx_len = tx_idx + 1;
        h0 = hs_cnt; r0 = txr_rises;
        start_c();
        wbyte({7'h26, 1'b1}, 8'h00, ack);
        check("t3_addr_ack", 32'(ack), 0);
        rbyte(d, 1'b1);
        check("t3_rd_dat", 32'(d), 32'h96);
        check("t3_txrdy_long", 32'(txr_run >= 200), 1);
        check("t3_stretch_long", 32'(scl_run >= 200), 1);
        repeat (50) @(negedge clk);
        check("t3_hs", 32'(hs_cnt - h0), 1);
        check("t3_no_more_rdy", 32'(txr_rises - r0), 1);
        check("t3_busy_ign", 32'(busy), 1);
        stop_c();
        repeat (10) @(negedge clk);
        check("t3_busy_clr", 32'(busy), 0);

        // T4: two-byte read with data already valid (1-clk stretch)
        txq[tx_idx] = 8'h01; txq[tx_idx + 1] = 8'hFE; tx_pre = 1'b1; tx_len = tx_idx + 2;
        h0 = hs_cnt; r0 = txr_rises;
        start_c();
        wbyte({7'h26, 1'b1}, 8'h00, ack);
        check("t4_addr_ack", 32'(ack), 0);
        rbyte(d, 1'b0);
        check("t4_rd0", 32'(d), 32'h01);
        check("t4_stretch0", 32'(scl_run), 1);
        rbyte(d, 1'b1);
        check("t4_rd1", 32'(d), 32'hFE);
        check("t4_stretch1", 32'(scl_run), 1);
        repeat (50) @(negedge clk);
        check("t4_hs", 32'(hs_cnt - h0), 2);
        check("t4_rdy_rises", 32'(txr_rises - r0), 2);
        stop_c();

        // T5: NACKed write, then repeated START into a read
        rx0 = rx_cnt;
        rx_rdy = 1'b0;
        txq[tx_idx] = 8'hC3; tx_len = tx_idx + 1;
        start_c();
        wbyte({7'h26, 1'b0}, 8'h00, ack);
        check("t5_addr_ack", 32'(ack), 0);
        wbyte(8'h55, 8'h00, ack);
        check("t5_data_nack", 32'(ack), 1);
        check("t5_rx_cnt", 32'(rx_cnt - rx0), 0);
        rx_rdy = 1'b1;
        start_c();
        wbyte({7'h26, 1'b1}, 8'h00, ack);
        check("t5_rd_ack", 32'(ack), 0);
        rbyte(d, 1'b1);
        check("t5_rd_dat", 32'(d), 32'hC3);
        stop_c();

        // T6: reset in the middle of the 4th read bit
        txq[tx_idx] = 8'hA5; tx_len = tx_idx + 1;
        start_c();
        wbyte({7'h26, 1'b1}, 8'h00, ack);
        check("t6_addr_ack", 32'(ack), 0);
        for (int i = 0; i < 3; i++) rbit(b);
        sda_m = 1'b1;
        hp();
        scl_up();
        repeat (HP/2) @(negedge clk);
        check("t6_sda_driven", 32'(sda_e), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_rst_outs", 32'({scl_e, sda_e, rx_vld, rx_dat, tx_rdy, busy, sto}), 0);
        tx_pre = 1'b0;
        sda_m  = 1'b1;
        repeat (40) @(negedge clk);
        rx0 = rx_cnt;
        start_c();
        wbyte({7'h26, 1'b0}, 8'h00, ack);
        check("t6_wr_addr_ack", 32'(ack), 0);
        wbyte(8'hA5, 8'h00, ack);
        check("t6_wr_data_ack", 32'(ack), 0);
        check("t6_rx_cnt", 32'(rx_cnt - rx0), 1);
        check("t6_rx_dat", 32'(rx_dat), 32'hA5);
        stop_c();

        // T7: 1-clk SDA glitches while SCL is high (fake START and fake STOP)
        start_c();
        wbyte({7'h26, 1'b0}, 8'h00, ack);
        check("t7_addr_ack", 32'(ack), 0);
        s0 = sto_cnt; rx0 = rx_cnt;
        wbyte(8'hC3, 8'b1010_0000, ack);
        check("t7_data_ack", 32'(ack), 0);
        check("t7_busy", 32'(busy), 1);
        check("t7_no_sto", 32'(sto_cnt - s0), 0);
        check("t7_rx_cnt", 32'(rx_cnt - rx0), 1);
        check("t7_rx_dat", 32'(rx_dat), 32'hC3);
        stop_c();
        repeat (10) @(negedge clk);

        check("rx_pulse_width", 32'(rx_wide), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sockit_i2c_slave.md
Name: sockit_i2c_slave

Overview:
- Synthesizable I2C target that sits directly downstream of the shared open-drain scl/sda bus driven by the I2C master.
- Converts bus transactions into a byte-stream interface for the local register/FIFO logic.
- Detects START, repeated START and STOP, matches a fixed 7-bit address, and ACKs written bytes.
- Supplies read bytes through a valid/ready handshake, stretching SCL when read data is not ready.

Parameters:
ADR, 7'h26, own 7-bit device address
FLT, 3, glitch-filter length in clk cycles; a filtered input changes only after FLT consecutive equal samples

Ports:
clk     input   1  system clock; all logic on rising edge
rst     input   1  synchronous active-high reset
scl_i   input   1  SCL line sample (asynchronous)
scl_e   output  1  SCL pull-low enable (1 = drive 0, 0 = release)
sda_i   input   1  SDA line sample (asynchronous)
sda_e   output  1  SDA pull-low enable
rx_vld  output  1  written-byte strobe, one clk
rx_dat  output  8  written byte, stable until next rx_vld
rx_rdy  input   1  local side accepts a byte; sampled at bit 8; 0 means NACK
tx_vld  input   1  read byte available
tx_dat  input   8  read byte, MSB first
tx_rdy  output  1  slave is waiting for a read byte; transfer when tx_vld & tx_rdy
busy    output  1  addressed and in a transaction (set at address ACK, cleared at STOP/START)
sto     output  1  one-clk pulse on any STOP seen

Behaviour:
- Reset values: scl_e=0, sda_e=0, rx_vld=0, rx_dat=0, tx_rdy=0, busy=0, sto=0; synchronizers and filters preset to 1; FSM in IDLE.
- Rst is honoured at any time, including mid-byte; the lines are released in the same clk.
- Input path: 2-FF synchronizer followed by the FLT filter; detect latency is 2+FLT clk. All edge detection uses the filtered scl_f/sda_f.
- START/repeated START: sda_f falls while scl_f=1. STOP: sda_f rises while scl_f=1.
  - Both are valid in any state.
  - Each releases sda_e and scl_e and clears busy.
  - START goes to ADDR with the bit counter at 0; STOP goes to IDLE and pulses sto.
- Sampling and driving:
  - Data is sampled on the scl_f rising edge.
  - sda_e is updated 1 clk after the scl_f falling edge, so it never changes while scl_f=1.
- FSM states:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7 address bits, then R/W). After the 8th rise:
    - Address match: go to A_ACK.
    - No match: go to IGNORE, which exits only on START or STOP.
  - A_ACK: drive sda_e=1 for the 9th bit; busy=1.
    - At the 9th-bit falling edge, R/W=0 goes to WR, R/W=1 goes to RD_LD.
  - WR: shift 8 bits. At the 8th rise:
    - If rx_rdy=1: rx_dat<=byte, rx_vld pulses the next clk, then W_ACK drives sda_e=1.
    - If rx_rdy=0: no strobe, sda_e=0 (NACK), and the byte is dropped.
    - Then back to WR for the next byte.
  - RD_LD: entered with scl_f low. Hold scl_e=1 and tx_rdy=1 until tx_vld.
    - On handshake, load the shift register, set sda_e=~tx_dat[7], release scl_e, clear tx_rdy, go to RD.
    - If tx_vld is already high on entry, the stretch lasts exactly 1 clk.
  - RD: update sda_e after each falling edge for bits 6..0. After the 8th fall, release sda for the master ACK bit.
  - R_ACK: sample sda_f at the 9th rise.
    - 0 (ACK): go to RD_LD at the following fall.
    - 1 (NACK): go to IGNORE with lines released.
- A STOP or START while in RD_LD drops the pending request: tx_rdy=0 and scl_e=0 in the next clk.
- Simultaneous rx_vld and START/STOP: the strobe completes, then the state change is applied.

Test Plan:
- Master writes addr 7'h26 W, byte 8'hA5, STOP, with rx_rdy=1 → address ACKed (sda low on bit 9); rx_vld one pulse with rx_dat=8'hA5; data ACKed; sto pulse; busy 0→1→0.
- Address 7'h27 W, byte 8'h3C → no ACK at bit 9; no rx_vld; sda_e/scl_e stay 0 through STOP.
- Addr 26 R with tx_vld held low for 200 clk, then tx_dat=8'h96 → scl_e=1 and tx_rdy=1 for ≥200 clk; master reads 8'h96; master NACK → IGNORE, no further tx_rdy.
- Addr 26 R, two bytes 8'h01, 8'hFE with master ACK then NACK → two handshakes; master reads 01, FE; sequence ends in IGNORE.
- Write 8'h55 with rx_rdy=0 → NACK on bit 9, no rx_vld; repeated START then addr 26 R → read proceeds normally.
- Assert rst in the middle of the 4th bit of a read → next clk all outputs at reset values; a subsequent full write of 8'hA5 succeeds.
- 1-clk SDA glitch while SCL is high, FLT=3 → no START/STOP detected; FSM state unchanged.
